// File: rtl/mux_pkg.sv
// Shared constants for the write-back word selector and its statistics counter.
// Latency: none (package only).
// Backpressure: none (package only).
package mux_pkg;

    // Default data path width (write-back word).
    localparam int DATA_W = 32;

    // Default width of the select-statistics counter.
    localparam int CNT_W_DEF = 16;

    // Values loaded into the registered view while rst_n is low.
    localparam logic [DATA_W-1:0] RST_WORD = '0;
    localparam logic              RST_SEL  = 1'b0;

endpackage

// File: rtl/mux2_sel32_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment, holds at all-ones.
// Latency: count reflects clr/inc one clk edge after they are sampled.
// Backpressure: none; inc is taken every cycle it is high until saturation.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, then increment unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mux2_sel32.sv
// 2:1 word selector with combinational output and a registered copy of result and select.
// Latency: out is 0-cycle; out_q/sel_q are 1 cycle; optional sel1_cnt (MUX_STATS_EN) is 1 cycle.
// Backpressure: none; every cycle is captured, there is no handshake or stall.
module mux2_sel32
    import mux_pkg::*;
#(
    parameter int WIDTH = DATA_W
`ifdef MUX_STATS_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q
`ifdef MUX_STATS_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sel1_cnt
`endif
);

    logic [WIDTH-1:0] out_d;
    logic             sel_d;

    // Select path: purely combinational, independent of clock and reset.
    always_comb begin
        out_d = sel ? in1 : in0;
        sel_d = sel;
    end

    assign out = out_d;

    // Registered view of the selected word and the select that chose it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= WIDTH'(RST_WORD);
            sel_q <= RST_SEL;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
        end
    end

`ifdef MUX_STATS_EN
    // Counts cycles with sel=1 since reset or the last clear.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sel1_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (sel),
        .count (sel1_cnt)
    );
`endif

endmodule

// File: tb/tb_mux2_sel32.sv
// Bench for mux2_sel32: directed scenarios then random traffic, scoreboard-checked.
// Latency: expects out in the same cycle, out_q/sel_q (and sel1_cnt) one edge later.
// Backpressure: none exercised; the DUT accepts every cycle.
module tb_mux2_sel32;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic        clk;
    logic        rst_n;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        sel;
    logic [31:0] out;
    logic [31:0] out_q;
    logic        sel_q;
`ifdef MUX_STATS_EN
    logic                cnt_clr;
    logic [TB_CNT_W-1:0] sel1_cnt;
`endif

    typedef struct {
        logic [31:0] word;
        logic        s;
        int          cnt;
    } reg_exp_t;

    logic [31:0] comb_q[$];
    reg_exp_t    reg_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_model = 0;

    mux2_sel32 #(
        .WIDTH (32)
`ifdef MUX_STATS_EN
        ,
        .CNT_W (TB_CNT_W)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in0   (in0),
        .in1   (in1),
        .sel   (sel),
        .out   (out),
        .out_q (out_q),
        .sel_q (sel_q)
`ifdef MUX_STATS_EN
        ,
        .cnt_clr  (cnt_clr),
        .sel1_cnt (sel1_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and record what the DUT must show for it.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c);
        logic [31:0] words [2];
        logic [31:0] pick;
        reg_exp_t    e;
        @(posedge clk);
        #1;
        rst_n = r;
        in0   = a;
        in1   = b;
        sel   = s;
`ifdef MUX_STATS_EN
        cnt_clr = c;
`endif
        words[0] = a;
        words[1] = b;
        pick = words[s ? 1 : 0];
        comb_q.push_back(pick);
        if (!r) begin
            e.word    = 32'h0;
            e.s       = 1'b0;
            cnt_model = 0;
        end else begin
            e.word = pick;
            e.s    = s;
            if (c)
                cnt_model = 0;
            else if (s)
                cnt_model = (cnt_model + 1 > CNT_MAX) ? CNT_MAX : cnt_model + 1;
        end
        e.cnt = cnt_model;
        reg_q.push_back(e);
    endtask

    // Monitor: combinational result checked in its own cycle, registered view one edge later.
    always @(negedge clk) begin
        logic [31:0] ec;
        reg_exp_t    er;
        if (comb_q.size() > 0) begin
            ec = comb_q.pop_front();
            n_cmp++;
            if (out !== ec) begin
                n_bad++;
                $display("FAIL out: got %h want %h at %0t", out, ec, $time);
            end
        end
        if (reg_q.size() > 1) begin
            er = reg_q.pop_front();
            n_cmp++;
            if (out_q !== er.word) begin
                n_bad++;
                $display("FAIL out_q: got %h want %h at %0t", out_q, er.word, $time);
            end
            n_cmp++;
            if (sel_q !== er.s) begin
                n_bad++;
                $display("FAIL sel_q: got %b want %b at %0t", sel_q, er.s, $time);
            end
`ifdef MUX_STATS_EN
            n_cmp++;
            if (int'(sel1_cnt) != er.cnt) begin
                n_bad++;
                $display("FAIL sel1_cnt: got %0d want %0d at %0t", sel1_cnt, er.cnt, $time);
            end
`endif
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        rr;
        logic        rc;
        rst_n = 1'b0;
        in0   = '0;
        in1   = '0;
        sel   = 1'b0;
`ifdef MUX_STATS_EN
        cnt_clr = 1'b0;
`endif
        // Reset held two edges with sel=1: out tracks in1, registered view stays zero.
        step(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        // Select toggling 0 -> 1 with distinct words.
        step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // Mid-stream reset after a known registered value, then recovery.
        step(1'b1, 32'h1234_5678, 32'h0BAD_F00D, 1'b0, 1'b0);
        step(1'b0, 32'h1234_5678, 32'h0BAD_F00D, 1'b1, 1'b0);
        step(1'b1, 32'h1234_5678, 32'h0BAD_F00D, 1'b1, 1'b0);
        step(1'b1, 32'h1234_5678, 32'h0BAD_F00D, 1'b0, 1'b0);
        // Equal inputs: select must not matter.
        step(1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 1'b0);
        step(1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1, 1'b0);
        // Statistics: clear, pattern 1,0,1,1, then saturation and clear-with-sel.
        step(1'b1, 32'h1, 32'h2, 1'b0, 1'b1);
        step(1'b1, 32'h1, 32'h2, 1'b1, 1'b0);
        step(1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
        step(1'b1, 32'h1, 32'h2, 1'b1, 1'b0);
        step(1'b1, 32'h1, 32'h2, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'h3 + i, 32'h100 + i, 1'b1, 1'b0);
        step(1'b1, 32'h7, 32'h8, 1'b1, 1'b1);
        step(1'b1, 32'h7, 32'h8, 1'b0, 1'b0);
        // Random traffic with occasional resets and clears.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = $urandom_range(0, 1) == 1;
            rr = $urandom_range(0, 49) != 0;
            rc = $urandom_range(0, 19) == 0;
            step(rr, ra, rb, rs, rc);
        end
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
